// File: rtl/aes_core_arbiter.sv
// aes_core_arbiter
//   Shares one aes_top core between two command requesters. Whole commands are
//   arbitrated round-robin. A shadow key is kept per requester, and the
//   arbiter tracks whose key is currently expanded in the core. An ENCRYPT
//   from a requester whose key is not loaded first runs a core SET_KEY.
//
// Ports
//   aclk, aresetn          clock, asynchronous active-low reset
//   req_valid/req_ready    per-requester command handshake (2 bits each)
//   req_cmd/key/data       packed per-requester command, key and plaintext;
//                          requester i occupies slice [i*W +: W]
//   resp_valid/resp_ready  per-requester response handshake (2 bits each)
//   resp_data, resp_err    shared response bus, qualified by resp_valid
//   err_cmd                one-cycle pulse when an unknown command is dropped
//   core_*                 interface to aes_top (en, cmd, key, plaintext,
//                          ciphertext, done)
//   dbg_state              current FSM state
//
// Handshake semantics: a transfer happens on a rising edge where valid and
// ready are both high. req_ready is combinational and is only raised in IDLE,
// for the single granted requester. resp_valid is held, with data and error
// stable, until resp_ready is seen. Neither side may make valid depend on ready.
module aes_core_arbiter #(
    parameter int              BLK_W       = 128,
    parameter int              KEY_W       = 128,
    parameter int              CMD_W       = 32,
    // Command encodings shared with aes_top.
    parameter logic [CMD_W-1:0] CMD_SET_KEY = 'h1,
    parameter logic [CMD_W-1:0] CMD_ENCRYPT = 'h2
) (
    input  logic               aclk,
    input  logic               aresetn,
    input  logic [1:0]         req_valid,
    output logic [1:0]         req_ready,
    input  logic [2*CMD_W-1:0] req_cmd,
    input  logic [2*KEY_W-1:0] req_key,
    input  logic [2*BLK_W-1:0] req_data,
    output logic [1:0]         resp_valid,
    input  logic [1:0]         resp_ready,
    output logic [BLK_W-1:0]   resp_data,
    output logic               resp_err,
    output logic               err_cmd,
    output logic               core_en,
    output logic [CMD_W-1:0]   core_cmd,
    output logic [KEY_W-1:0]   core_key,
    output logic [BLK_W-1:0]   core_plaintext,
    input  logic [BLK_W-1:0]   core_ciphertext,
    input  logic               core_done,
    output logic [2:0]         dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_KEY      = 3'd1,
        S_KEY_WAIT = 3'd2,
        S_ENC      = 3'd3,
        S_ENC_WAIT = 3'd4,
        S_RESP     = 3'd5
    } state_t;

    state_t             state, state_nxt;
    logic               last_grant;
    logic               grant;          // requester owning the current command
    logic               gnt;            // combinational round-robin winner
    logic               accept;
    logic [CMD_W-1:0]   acc_cmd;
    logic [KEY_W-1:0]   acc_key;
    logic [BLK_W-1:0]   acc_data;
    logic               is_set, is_enc;
    logic [KEY_W-1:0]   shadow_key [2];
    logic [1:0]         shadow_valid;
    logic               key_loaded;
    logic               key_owner;
    logic [BLK_W-1:0]   data_r;

    // Round-robin: with both requesting, the one not granted last wins.
    always_comb begin
        gnt = 1'b0;
        case (req_valid)
            2'b11:   gnt = ~last_grant;
            2'b10:   gnt = 1'b1;
            default: gnt = 1'b0;
        endcase
        accept   = (state == S_IDLE) && (req_valid != 2'b00);
        acc_cmd  = gnt ? req_cmd[2*CMD_W-1:CMD_W]  : req_cmd[CMD_W-1:0];
        acc_key  = gnt ? req_key[2*KEY_W-1:KEY_W]  : req_key[KEY_W-1:0];
        acc_data = gnt ? req_data[2*BLK_W-1:BLK_W] : req_data[BLK_W-1:0];
        is_set   = (acc_cmd == CMD_SET_KEY);
        is_enc   = (acc_cmd == CMD_ENCRYPT);
        req_ready = 2'b00;
        if (accept) begin
            req_ready[gnt] = 1'b1;
        end
        resp_valid = 2'b00;
        if (state == S_RESP) begin
            resp_valid[grant] = 1'b1;
        end
    end

    assign core_en   = (state == S_KEY) || (state == S_ENC);
    assign dbg_state = state;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept && is_enc) begin
                    if (!shadow_valid[gnt]) begin
                        state_nxt = S_RESP;
                    end else if (key_loaded && (key_owner == gnt)) begin
                        state_nxt = S_ENC;
                    end else begin
                        state_nxt = S_KEY;
                    end
                end
            end
            S_KEY:      state_nxt = S_KEY_WAIT;
            S_KEY_WAIT: if (core_done) state_nxt = S_ENC;
            S_ENC:      state_nxt = S_ENC_WAIT;
            S_ENC_WAIT: if (core_done) state_nxt = S_RESP;
            S_RESP:     if (resp_ready[grant]) state_nxt = S_IDLE;
            default:    state_nxt = S_IDLE;
        endcase
    end

    // Core operands are loaded on the edge that enters KEY/ENC so they are
    // already stable while core_en is high, and held until core_done.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            last_grant      <= 1'b1;
            grant           <= 1'b0;
            data_r          <= '0;
            shadow_key[0]   <= '0;
            shadow_key[1]   <= '0;
            shadow_valid    <= 2'b00;
            key_loaded      <= 1'b0;
            key_owner       <= 1'b0;
            core_cmd        <= '0;
            core_key        <= '0;
            core_plaintext  <= '0;
            resp_data       <= '0;
            resp_err        <= 1'b0;
            err_cmd         <= 1'b0;
        end else begin
            err_cmd <= 1'b0;
            if (accept) begin
                last_grant <= gnt;
                grant      <= gnt;
                data_r     <= acc_data;
                if (is_set) begin
                    shadow_key[gnt]   <= acc_key;
                    shadow_valid[gnt] <= 1'b1;
                    // The expanded key in the core is now stale for this owner.
                    if (key_owner == gnt) begin
                        key_loaded <= 1'b0;
                    end
                end else if (is_enc) begin
                    if (!shadow_valid[gnt]) begin
                        resp_data <= '0;
                        resp_err  <= 1'b1;
                    end else if (key_loaded && (key_owner == gnt)) begin
                        core_cmd       <= CMD_ENCRYPT;
                        core_plaintext <= acc_data;
                    end else begin
                        core_cmd <= CMD_SET_KEY;
                        core_key <= shadow_key[gnt];
                    end
                end else begin
                    err_cmd <= 1'b1;
                end
            end
            if ((state == S_KEY_WAIT) && core_done) begin
                key_loaded     <= 1'b1;
                key_owner      <= grant;
                core_cmd       <= CMD_ENCRYPT;
                core_plaintext <= data_r;
            end
            if ((state == S_ENC_WAIT) && core_done) begin
                resp_data <= core_ciphertext;
                resp_err  <= 1'b0;
            end
        end
    end

endmodule
